// File: rtl/camera_registers_pkg.sv
// Shared types and constants for the OV5640 SCCB register loader.
package camera_registers_pkg;

    // Sequencer states of the register loader.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        START,
        BYTE,
        ACK,
        STOP,
        GAP
    } state_e;

    // Bus operations handed to the bit engine.
    typedef enum logic [1:0] {
        OP_START,
        OP_BYTE,
        OP_ACK,
        OP_STOP
    } tx_op_e;

    // A ROM entry of all zeros ends the init table.
    localparam logic [23:0] ROM_TERMINATOR   = 24'h000000;
    // OV5640 SCCB write address.
    localparam logic [7:0]  DEFAULT_DEV_ADDR = 8'h78;
    // Highest ROM address; the table never wraps past it.
    localparam logic [8:0]  LAST_ROM_ADDR    = 9'd511;

    // Index of the final quarter-period of each bus operation.
    function automatic logic [4:0] last_quarter(tx_op_e op);
        case (op)
            OP_START: last_quarter = 5'd1;   // SDA fall, SCL fall
            OP_BYTE:  last_quarter = 5'd31;  // 8 bits x 4 quarters
            OP_ACK:   last_quarter = 5'd3;   // one 4-quarter clock
            default:  last_quarter = 5'd2;   // STOP: SDA low, SCL up, SDA up
        endcase
    endfunction

endpackage

// File: rtl/camera_registers_sccb_byte_tx.sv
// SCCB bit engine: runs one START, data byte, ACK clock or STOP per request.
// Pin levels are registered and held between requests so the bus never
// moves while the sequencer is deciding what comes next.
module sccb_byte_tx
    import camera_registers_pkg::*;
#(
    parameter int SCL_QDIV = 250
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start,
    input  tx_op_e     op,
    input  logic [7:0] data,
    input  logic       sda_in,
    output logic       done,
    output logic       nack,
    output logic       scl_low,
    output logic       sda_low
);

    localparam int               DIV_W    = (SCL_QDIV > 1) ? $clog2(SCL_QDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCL_QDIV - 1);

    logic             busy_q,    busy_d;
    tx_op_e           op_q,      op_d;
    logic [7:0]       data_q,    data_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [4:0]       qtr_q,     qtr_d;
    logic             scl_low_q, scl_low_d;
    logic             sda_low_q, sda_low_d;
    logic             nack_q,    nack_d;
    logic             quarter_end;

    // {scl_low, sda_low} for quarter q of an operation. Data/ACK bits:
    // q0 SCL low with SDA set up, q1-q2 SCL high, q3 SCL low.
    function automatic logic [1:0] bus_levels(tx_op_e o, logic [4:0] q, logic [7:0] d);
        logic clk_low;
        clk_low = (q[1:0] == 2'd0) || (q[1:0] == 2'd3);
        case (o)
            OP_START: bus_levels = {q[0], 1'b1};
            OP_BYTE:  bus_levels = {clk_low, ~d[3'd7 - q[4:2]]};
            OP_ACK:   bus_levels = {clk_low, 1'b0};
            default:  bus_levels = {(q == 5'd0), (q != 5'd2)};
        endcase
    endfunction

    // Accept a request when idle, then step quarters until the last one ends.
    always_comb begin
        busy_d      = busy_q;
        op_d        = op_q;
        data_d      = data_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        scl_low_d   = scl_low_q;
        sda_low_d   = sda_low_q;
        nack_d      = nack_q;
        quarter_end = busy_q && (div_q == DIV_LAST);
        done        = quarter_end && (qtr_q == last_quarter(op_q));
        if (!busy_q) begin
            if (start) begin
                busy_d                 = 1'b1;
                op_d                   = op;
                data_d                 = data;
                div_d                  = '0;
                qtr_d                  = '0;
                {scl_low_d, sda_low_d} = bus_levels(op, 5'd0, data);
            end
        end else if (!quarter_end) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            // End of q1 is the middle of the high phase of the ACK clock.
            if (op_q == OP_ACK && qtr_q == 5'd1) begin
                nack_d = sda_in;
            end
            if (done) begin
                busy_d = 1'b0;
                qtr_d  = '0;
            end else begin
                qtr_d                  = qtr_q + 5'd1;
                {scl_low_d, sda_low_d} = bus_levels(op_q, qtr_q + 5'd1, data_q);
            end
        end
    end

    // State and pin-drive registers; reset releases both lines at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q    <= 1'b0;
            op_q      <= OP_START;
            data_q    <= '0;
            div_q     <= '0;
            qtr_q     <= '0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            op_q      <= op_d;
            data_q    <= data_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            nack_q    <= nack_d;
        end
    end

    assign scl_low = scl_low_q;
    assign sda_low = sda_low_q;
    assign nack    = nack_q;

endmodule

// File: rtl/camera_registers.sv
// OV5640 register loader: walks a ROM of {reg_addr, data} entries and writes
// each one over SCCB until a zero entry or the end of the ROM.
module camera_registers
    import camera_registers_pkg::*;
#(
    parameter int         SCL_QDIV = 250,
    parameter logic [7:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        init_valid,
    output logic        init_ready,
    inout  wire         scl_pin,
    inout  wire         sda_pin,
    output logic [8:0]  bram_addr,
    input  logic [23:0] bram_dout
);

    localparam int               DIV_W    = (SCL_QDIV > 1) ? $clog2(SCL_QDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCL_QDIV - 1);

    state_e           state_q,    state_d;
    logic [8:0]       addr_q,     addr_d;
    logic             wait_q,     wait_d;
    logic [23:0]      entry_q,    entry_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [DIV_W-1:0] gdiv_q,     gdiv_d;
    logic [1:0]       gqtr_q,     gqtr_d;
    logic             tx_start_q, tx_start_d;
    tx_op_e           tx_op_q,    tx_op_d;
    logic [7:0]       tx_data_q,  tx_data_d;

    logic tx_done;
    logic tx_nack;
    logic nack_unused;
    logic scl_low;
    logic sda_low;
    logic sda_in;

    // Byte n of the current write: device address, reg high, reg low, data.
    function automatic logic [7:0] tx_byte(logic [1:0] idx, logic [23:0] e);
        case (idx)
            2'd0:    tx_byte = DEV_ADDR;
            2'd1:    tx_byte = e[23:16];
            2'd2:    tx_byte = e[15:8];
            default: tx_byte = e[7:0];
        endcase
    endfunction

    // Sequencer: ROM fetch, then START / 4x(BYTE, ACK) / STOP / GAP per entry.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_d     = 1'b0;
        entry_d    = entry_q;
        byte_idx_d = byte_idx_q;
        gdiv_d     = '0;
        gqtr_d     = '0;
        tx_start_d = 1'b0;
        tx_op_d    = tx_op_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (init_valid) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Two cycles after the address moved, the ROM output is valid.
                if (wait_q) state_d = CHECK;
                else        wait_d  = 1'b1;
            end
            CHECK: begin
                if (bram_dout == ROM_TERMINATOR) begin
                    state_d = IDLE;
                end else begin
                    entry_d    = bram_dout;
                    state_d    = START;
                    tx_start_d = 1'b1;
                    tx_op_d    = OP_START;
                end
            end
            START: begin
                if (tx_done) begin
                    state_d    = BYTE;
                    byte_idx_d = 2'd0;
                    tx_start_d = 1'b1;
                    tx_op_d    = OP_BYTE;
                    tx_data_d  = tx_byte(2'd0, entry_q);
                end
            end
            BYTE: begin
                if (tx_done) begin
                    state_d    = ACK;
                    tx_start_d = 1'b1;
                    tx_op_d    = OP_ACK;
                end
            end
            ACK: begin
                // SCCB ninth bit is don't-care: a NACK never changes the path.
                if (tx_done) begin
                    tx_start_d = 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = STOP;
                        tx_op_d = OP_STOP;
                    end else begin
                        state_d    = BYTE;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_op_d    = OP_BYTE;
                        tx_data_d  = tx_byte(byte_idx_q + 2'd1, entry_q);
                    end
                end
            end
            STOP: begin
                if (tx_done) state_d = GAP;
            end
            GAP: begin
                // Bus idle for four quarters before the next entry.
                gqtr_d = gqtr_q;
                if (gdiv_q != DIV_LAST) begin
                    gdiv_d = gdiv_q + 1'b1;
                end else if (gqtr_q != 2'd3) begin
                    gqtr_d = gqtr_q + 2'd1;
                end else begin
                    gqtr_d = '0;
                    if (addr_q == LAST_ROM_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 9'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any transfer without a STOP.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wait_q     <= 1'b0;
            entry_q    <= '0;
            byte_idx_q <= '0;
            gdiv_q     <= '0;
            gqtr_q     <= '0;
            tx_start_q <= 1'b0;
            tx_op_q    <= OP_START;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            entry_q    <= entry_d;
            byte_idx_q <= byte_idx_d;
            gdiv_q     <= gdiv_d;
            gqtr_q     <= gqtr_d;
            tx_start_q <= tx_start_d;
            tx_op_q    <= tx_op_d;
            tx_data_q  <= tx_data_d;
        end
    end

    sccb_byte_tx #(
        .SCL_QDIV (SCL_QDIV)
    ) u_tx (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start   (tx_start_q),
        .op      (tx_op_q),
        .data    (tx_data_q),
        .sda_in  (sda_in),
        .done    (tx_done),
        .nack    (tx_nack),
        .scl_low (scl_low),
        .sda_low (sda_low)
    );

    // Acknowledge status is captured but intentionally not acted on.
    assign nack_unused = tx_nack;

    // Open-drain pads: pull low or float, the pull-up supplies the 1.
    assign scl_pin = scl_low ? 1'b0 : 1'bz;
    assign sda_pin = sda_low ? 1'b0 : 1'bz;
    assign sda_in  = sda_pin;

    assign init_ready = (state_q == IDLE);
    assign bram_addr  = addr_q;

endmodule

// File: tb/tb_camera_registers.sv
// Bench for camera_registers: ROM model, ACKing slave, SCCB bus decoder with
// an expected-event scoreboard, plus direct reset checks.
module tb_camera_registers;

    localparam int QDIV     = 5;
    localparam int EV_START = 32'h100;
    localparam int EV_STOP  = 32'h200;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        init_valid;
    logic        init_ready;
    logic [8:0]  bram_addr;
    logic [23:0] bram_dout;
    wire         scl_w;
    wire         sda_w;

    logic [23:0] rom [512];
    logic [23:0] rom_p1;
    logic        slave_en;
    logic        slave_drive;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = slave_drive ? 1'b0 : 1'bz;

    camera_registers #(
        .SCL_QDIV (QDIV),
        .DEV_ADDR (8'h78)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .scl_pin    (scl_w),
        .sda_pin    (sda_w),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle-latency ROM and cycle counter.
    always @(posedge clk_in) begin
        rom_p1    <= rom[bram_addr];
        bram_dout <= rom_p1;
        cyc       <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] e);
        exp_q.push_back(EV_START);
        exp_q.push_back(32'h78);
        exp_q.push_back(int'(e[23:16]));
        exp_q.push_back(int'(e[15:8]));
        exp_q.push_back(int'(e[7:0]));
        exp_q.push_back(EV_STOP);
    endtask

    task automatic take_event(input int ev);
        if (exp_q.size() == 0) chk("bus_event_unexpected", ev, -1);
        else                   chk("bus_event", ev, exp_q.pop_front());
    endtask

    task automatic pulse_valid();
        @(posedge clk_in); #1 init_valid = 1'b1;
        @(posedge clk_in); #1 init_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int to = 1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_in); #1;
            if (init_ready) begin to = 0; break; end
        end
        chk("idle_timeout", to, 0);
    endtask

    task automatic wait_addr(input logic [8:0] a, input int limit);
        int to = 1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_in); #1;
            if (bram_addr == a) begin to = 0; break; end
        end
        chk("addr_timeout", to, 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 24'h0;
    endtask

    // Bus decoder and slave: START/STOP, bytes, SCL timing, ACK pull-down.
    initial begin
        logic       s, d, ps, pd, meas_high;
        logic [7:0] sh;
        int         bitcnt, last_rise;
        ps = 1'b1; pd = 1'b1; meas_high = 1'b0; sh = '0;
        bitcnt = 0; last_rise = 0; slave_drive = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_in !== 1'b1) begin
                ps = 1'b1; pd = 1'b1; bitcnt = 0;
                meas_high = 1'b0; slave_drive = 1'b0;
            end else begin
                s = scl_w;
                d = sda_w;
                if (ps && s && pd && !d) begin
                    take_event(EV_START);
                    bitcnt = 0; meas_high = 1'b0;
                end else if (ps && s && !pd && d) begin
                    take_event(EV_STOP);
                    bitcnt = 0; meas_high = 1'b0;
                end else if (!ps && s) begin
                    sh = {sh[6:0], d};
                    bitcnt++;
                    if (bitcnt >= 2 && bitcnt <= 8) chk("scl_period", cyc - last_rise, 4 * QDIV);
                    last_rise = cyc;
                    meas_high = 1'b1;
                    if (bitcnt == 8) take_event(int'(sh));
                    else if (bitcnt == 9) bitcnt = 0;
                end else if (ps && !s) begin
                    if (meas_high) chk("scl_high", cyc - last_rise, 2 * QDIV);
                    meas_high = 1'b0;
                    if (bitcnt == 8 && slave_en) slave_drive = 1'b1;
                    else if (bitcnt == 0)        slave_drive = 1'b0;
                end
                ps = s;
                pd = d;
            end
        end
    end

    // Directed stimulus.
    initial begin
        rst_in = 1'b0; init_valid = 1'b0; slave_en = 1'b1;
        clear_rom();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", init_ready, 1);
        chk("rst_addr",  bram_addr, 0);
        chk("rst_scl",   scl_w, 1);
        chk("rst_sda",   sda_w, 1);
        rst_in = 1'b1;

        // Single write, then terminator at address 1.
        rom[0] = 24'hAABBCC;
        push_frame(24'hAABBCC);
        pulse_valid();
        chk("busy_ready", init_ready, 0);
        wait_idle(3000);
        chk("single_addr", bram_addr, 1);
        chk("single_drained", exp_q.size(), 0);

        // Repeated identical entries until the zero entry.
        clear_rom();
        for (int i = 0; i < 3; i++) begin
            rom[i] = 24'hAABBCC;
            push_frame(24'hAABBCC);
        end
        pulse_valid();
        wait_idle(8000);
        chk("repeat_addr", bram_addr, 3);
        chk("repeat_drained", exp_q.size(), 0);

        // No slave present: everything still goes out.
        slave_en = 1'b0;
        clear_rom();
        rom[0] = 24'h123456; rom[1] = 24'h00FF01;
        push_frame(24'h123456);
        push_frame(24'h00FF01);
        pulse_valid();
        wait_idle(6000);
        chk("nack_addr", bram_addr, 2);
        chk("nack_drained", exp_q.size(), 0);
        slave_en = 1'b1;

        // Request while busy is ignored.
        clear_rom();
        rom[0] = 24'hC0FFEE; rom[1] = 24'h5A5A5A;
        push_frame(24'hC0FFEE);
        push_frame(24'h5A5A5A);
        pulse_valid();
        wait_addr(9'd1, 3000);
        pulse_valid();
        chk("busy_ignore_addr", bram_addr, 1);
        chk("busy_ignore_ready", init_ready, 0);
        wait_idle(6000);
        chk("busy_end_addr", bram_addr, 2);
        chk("busy_drained", exp_q.size(), 0);

        // Reset in the middle of a byte, then restart from address 0.
        clear_rom();
        rom[0] = 24'hAABBCC; rom[1] = 24'hDDEEFF;
        push_frame(24'hAABBCC);
        push_frame(24'hDDEEFF);
        pulse_valid();
        wait_addr(9'd1, 3000);
        repeat (230) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        chk("abort_scl", scl_w, 1);
        chk("abort_sda", sda_w, 1);
        chk("abort_ready", init_ready, 1);
        chk("abort_addr", bram_addr, 0);
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;
        push_frame(24'hAABBCC);
        push_frame(24'hDDEEFF);
        pulse_valid();
        wait_idle(6000);
        chk("restart_addr", bram_addr, 2);
        chk("restart_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_registers.md
CAMERA_REGISTERS -- requirements
Module: camera_registers

Interface
REQ-001 SHALL have parameter SCL_QDIV, default 250, giving clk_in cycles per quarter SCL period (100 MHz -> 100 kHz SCL).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h78, giving the 8-bit SCCB write address of the OV5640.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port init_valid, input, 1 bit: request to run the init sequence.
REQ-006 SHALL have port init_ready, output, 1 bit: idle and able to accept a request.
REQ-007 SHALL have port scl_pin, inout, 1 bit: open-drain SCCB clock.
REQ-008 SHALL have port sda_pin, inout, 1 bit: open-drain SCCB data.
REQ-009 SHALL have port bram_addr, output, 9 bits: ROM read address.
REQ-010 SHALL have port bram_dout, input, 24 bits: ROM entry {reg_addr[15:0], data[7:0]}.

Function
REQ-011 SHALL drive pins open-drain only: drive 0 or high-Z, never 1; a released line reads 1 via external pull-up.
REQ-012 SHALL accept a request on the rising clk_in edge where init_valid and init_ready are both 1; it then clears init_ready, sets bram_addr to 0 and starts FETCH. init_valid while busy SHALL be ignored.
REQ-013 SHALL use states IDLE, FETCH, CHECK, START, BYTE, ACK, STOP, GAP.
REQ-014 FETCH SHALL wait 2 cycles after any bram_addr change before sampling bram_dout (2-cycle ROM latency).
REQ-015 CHECK SHALL go to IDLE if the entry is 24'h000000 (terminator); otherwise it SHALL latch the entry and go to START.
REQ-016 SHALL write each transaction as 4 bytes, MSB first: DEV_ADDR, reg_addr[15:8], reg_addr[7:0], data.
REQ-017 START SHALL pull SDA low while SCL is high, then pull SCL low, one quarter period apart.
REQ-018 Each bit SHALL set SDA while SCL is low, raise SCL for 2 quarters, then lower SCL (4 quarters per bit).
REQ-019 ACK SHALL release SDA for the 9th clock, sample SDA at mid-high, and ignore a NACK; the sequence SHALL continue regardless (SCCB don't-care bit).
REQ-020 STOP SHALL take SDA low with SCL low, release SCL, then release SDA, one quarter apart.
REQ-021 GAP SHALL hold the bus idle (both released) for 4 quarters, then increment bram_addr and go to FETCH.
REQ-022 After the transaction at address 511 completes, SHALL return to IDLE without wrapping.
REQ-023 On return to IDLE, SHALL assert init_ready on the same cycle and leave bram_addr at its last value.
REQ-024 The quarter counter SHALL run only while busy and SHALL reset to 0 at every state entry.

Reset
REQ-025 While rst_in=0, SHALL immediately set state IDLE, init_ready=1, bram_addr=0, SCL and SDA released, and all counters 0.
REQ-026 Reset mid-transaction SHALL abort without generating a STOP.

Structure
REQ-027 A shared package SHALL hold the state enum, the terminator constant 24'h000000 and the default DEV_ADDR.
REQ-028 The design SHALL use one sub-module, sccb_byte_tx, for START, 8 bits plus ACK, and STOP generation under a start/done handshake; camera_registers owns sequencing and ROM access.

Verification
REQ-029 Reset: init_ready=1, bram_addr=0, both pins read 1 with pull-ups.
REQ-030 One-cycle init_valid pulse with ROM returning 24'hAABBCC -> SDA shows START, 0x78, 0xAA, 0xBB, 0xCC, STOP; SCL period 4*SCL_QDIV cycles; bram_addr then advances to 1.
REQ-031 ROM constant 24'hAABBCC, then 24'h000000 -> repeated identical transactions until the zero entry; then IDLE and init_ready=1.
REQ-032 No slave (SDA never pulled low at ACK) -> all 4 bytes and STOP still issued.
REQ-033 init_valid asserted while busy -> no restart, and bram_addr is not reset.
REQ-034 rst_in asserted low mid-byte -> pins released within the same cycle and init_ready=1; a new request then restarts at address 0.
